// File: rtl/rv32i_multiplier_unit.sv
// Sequential unsigned 16x16 -> 32 shift-and-add multiplier retiring BITS_PER_CYCLE
// multiplier bits per clock, with a request/valid handshake and abort on request drop.
module rv32i_multiplier_unit #(
    parameter int BITS_PER_CYCLE = 2  // legal values: 1, 2, 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_multiplier_en,
    input  logic [15:0] i_multiplier_operand_one,
    input  logic [15:0] i_multiplier_operand_two,
    output logic        o_multiplier_valid,
    output logic [31:0] o_multiplier_result,
    output logic        o_multiplier_busy
);

    localparam int N     = 16 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t           r_state,  w_state_next;
    logic [31:0]      r_mcand,  w_mcand_next;   // multiplicand, pre-shifted to the current bit position
    logic [15:0]      r_mplier, w_mplier_next;  // multiplier, consumed from the LSB end
    logic [31:0]      r_acc,    w_acc_next;
    logic [CNT_W-1:0] r_cnt,    w_cnt_next;
    logic             r_valid,  w_valid_next;
    logic [31:0]      r_result, w_result_next;
    logic [31:0]      w_partial;
    logic             w_early_out;

    always_comb begin
        w_partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    // Only the first BUSY edge sees the unshifted operands, so a zero check there is exact.
    assign w_early_out = (r_cnt == '0) && ((r_mcand == '0) || (r_mplier == '0));

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        w_state_next  = r_state;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_acc_next    = r_acc;
        w_cnt_next    = r_cnt;
        w_result_next = r_result;
        w_valid_next  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_multiplier_en) begin
                    w_mcand_next  = {16'b0, i_multiplier_operand_one};
                    w_mplier_next = i_multiplier_operand_two;
                    w_acc_next    = '0;
                    w_cnt_next    = '0;
                    w_state_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                // The completing edge finishes regardless of en; only earlier edges abort.
                if (w_early_out) begin
                    w_result_next = '0;
                    w_valid_next  = 1'b1;
                    w_state_next  = S_DONE;
                end else if (r_cnt == LAST) begin
                    w_result_next = r_acc + w_partial;
                    w_valid_next  = 1'b1;
                    w_state_next  = S_DONE;
                end else if (!i_multiplier_en) begin
                    w_state_next  = S_IDLE;
                end else begin
                    w_acc_next    = r_acc + w_partial;
                    w_mcand_next  = r_mcand << BITS_PER_CYCLE;
                    w_mplier_next = r_mplier >> BITS_PER_CYCLE;
                    w_cnt_next    = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = i_multiplier_en ? S_WAIT_LOW : S_IDLE;
            end
            S_WAIT_LOW: begin
                if (!i_multiplier_en) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_valid  <= w_valid_next;
            r_result <= w_result_next;
        end
    end

    assign o_multiplier_valid  = r_valid;
    assign o_multiplier_result = r_result;
    assign o_multiplier_busy   = (r_state == S_BUSY) || (r_state == S_DONE);

endmodule

// File: tb/tb_rv32i_multiplier_unit.sv
// Scoreboard bench for rv32i_multiplier_unit: driver pushes model products and latencies,
// a negedge monitor pops and compares on every valid pulse.
module tb_rv32i_multiplier_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] op1 = '0, op2 = '0;
    logic        valid, busy;
    logic [31:0] result;

    logic        en_x = 1'b0;
    logic [15:0] xa = '0, xb = '0;
    logic        v1, v4, bz1, bz4;
    logic [31:0] r1, r4;

    rv32i_multiplier_unit u_dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_multiplier_en          (en),
        .i_multiplier_operand_one (op1),
        .i_multiplier_operand_two (op2),
        .o_multiplier_valid       (valid),
        .o_multiplier_result      (result),
        .o_multiplier_busy        (busy)
    );

    rv32i_multiplier_unit #(.BITS_PER_CYCLE(1)) u_dut_b1 (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_multiplier_en          (en_x),
        .i_multiplier_operand_one (xa),
        .i_multiplier_operand_two (xb),
        .o_multiplier_valid       (v1),
        .o_multiplier_result      (r1),
        .o_multiplier_busy        (bz1)
    );

    rv32i_multiplier_unit #(.BITS_PER_CYCLE(4)) u_dut_b4 (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_multiplier_en          (en_x),
        .i_multiplier_operand_one (xa),
        .i_multiplier_operand_two (xb),
        .o_multiplier_valid       (v4),
        .o_multiplier_result      (r4),
        .o_multiplier_busy        (bz4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] result;
        int          c0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_result = '0;

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b, input int bpc);
        return (a == 16'd0 || b == 16'd0) ? 1 : 16 / bpc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Raise en with operands; the next rising edge is the capture edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit expect_done);
        exp_t e;
        op1 = a;
        op2 = b;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_capture", {31'b0, busy}, 32'd1);
        if (expect_done) begin
            e.result = model_prod(a, b);
            e.c0     = cyc;
            e.lat    = model_lat(a, b, 2);
            sb.push_back(e);
            last_result = e.result;
        end
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            seen = valid;
        end
        if (!seen) check("valid_timeout", {31'b0, valid}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'b0, valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.result);
                check("latency", 32'(cyc - e.c0), 32'(e.lat));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        int          mode, lat;

        #3;
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-range product, en held: exactly one valid, then WAIT_LOW.
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        wait_valid();
        repeat (12) @(negedge clk);
        check("wait_low_busy", {31'b0, busy}, 32'd0);
        en = 1'b0;
        @(posedge clk);
        #1;

        // Operand changes during BUSY are ignored.
        issue(16'h1234, 16'h0010, 1'b1);
        op1 = 16'hAAAA;
        op2 = 16'h5555;
        wait_valid();
        en = 1'b0;
        @(posedge clk);
        #1;

        // Zero operand early-out.
        issue(16'h0000, 16'hBEEF, 1'b1);
        wait_valid();
        en = 1'b0;
        @(posedge clk);
        #1;

        // Abort at BUSY iteration 3, then restart after a single low cycle.
        issue(16'h0055, 16'h0077, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result_hold", result, last_result);
        issue(16'h0003, 16'h0005, 1'b1);
        wait_valid();
        en = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-BUSY, away from any clock edge.
        issue(16'h00FF, 16'h0101, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("midbusy_reset_valid", {31'b0, valid}, 32'd0);
        check("midbusy_reset_result", result, 32'd0);
        check("midbusy_reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_result = '0;
        repeat (10) @(negedge clk);
        check("post_reset_result", result, 32'd0);
        check("post_reset_busy", {31'b0, busy}, 32'd0);
        issue(16'h1111, 16'h0003, 1'b1);
        wait_valid();
        en = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic with varied en release behaviour.
        for (int n = 0; n < 24; n++) begin
            a    = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            b    = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            mode = $urandom_range(0, 2);
            lat  = model_lat(a, b, 2);
            issue(a, b, 1'b1);
            if (mode == 1) begin
                // en low at the completing edge must still yield the pulse.
                repeat (lat - 1) @(posedge clk);
                #1;
                en = 1'b0;
                wait_valid();
            end else begin
                wait_valid();
                if (mode == 2) begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    check("rand_wait_low_busy", {31'b0, busy}, 32'd0);
                end
                en = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        // BITS_PER_CYCLE = 1 and 4 builds.
        for (int k = 0; k < 2; k++) begin
            bit got1, got4;
            int c0;
            logic [31:0] exp_p;
            xa = (k == 0) ? 16'h8001 : 16'($urandom);
            xb = (k == 0) ? 16'h0002 : 16'($urandom);
            exp_p = model_prod(xa, xb);
            en_x = 1'b1;
            @(posedge clk);
            #1;
            c0   = cyc;
            got1 = 1'b0;
            got4 = 1'b0;
            for (int t = 0; t < 30 && !(got1 && got4); t++) begin
                @(negedge clk);
                if (v1 && !got1) begin
                    got1 = 1'b1;
                    check("b1_result", r1, exp_p);
                    check("b1_latency", 32'(cyc - c0), 32'(model_lat(xa, xb, 1)));
                end
                if (v4 && !got4) begin
                    got4 = 1'b1;
                    check("b4_result", r4, exp_p);
                    check("b4_latency", 32'(cyc - c0), 32'(model_lat(xa, xb, 4)));
                end
            end
            if (!got1) check("b1_timeout", {31'b0, v1}, 32'd1);
            if (!got4) check("b4_timeout", {31'b0, v4}, 32'd1);
            en_x = 1'b0;
            @(posedge clk);
            #1;
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
